stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_timeout_cnt.sv | 32 +++
 rtl/stage_sequencer.sv | 128 ++++++++++++
 tb/tb_stage_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the stage sequencer: state encoding and stage count.
package seq_pkg;

    localparam int STAGE_COUNT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } stage_e;

    // Only loads and stores wait on the data memory.
    function automatic logic needs_mem(input logic ld, input logic st);
        return ld | st;
    endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// MEM-stage wait counter; at_limit flags that one more wait cycle would hit MEM_TIMEOUT.
module seq_timeout_cnt #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] cnt_r;

    // Wait-cycle counter, saturating at LIMIT since the FSM leaves MEM there.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {TW{1'b0}};
        end else if (clear) begin
            cnt_r <= {TW{1'b0}};
        end else if (inc && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + TW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = (cnt_r == LIMIT);

endmodule

// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer with MEM wait/timeout and sticky HALT/ERROR.
// Optional build macro: STAGE_SEQ_MEM_SKIP_EN (non-memory instructions bypass MEM).
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             uart_store,
    input  logic             uart_busy,
    input  logic             mem_ready,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             write_en,
    output logic [2:0]       stage,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retire_cnt
);

    stage_e           state_r;
    stage_e           next_s;
    logic [CNT_W-1:0] retire_r;
    logic             mem_op_s;
    logic             stall_s;
    logic             wait_inc_s;
    logic             wait_clr_s;
    logic             at_limit_s;

    assign mem_op_s   = needs_mem(is_load, is_store);
    assign stall_s    = uart_store & uart_busy;
    assign wait_clr_s = (state_r != ST_MEM);

    seq_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (wait_clr_s),
        .inc      (wait_inc_s),
        .at_limit (at_limit_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; MEM either advances, waits, or times out.
    always_comb begin
        next_s     = state_r;
        wait_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    next_s = ST_FETCH;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_FETCH:  next_s = ST_DECODE;
            ST_DECODE: next_s = ST_EXEC;
            ST_EXEC: begin
                if (is_halt) begin
                    next_s = ST_HALT;
                end
`ifdef STAGE_SEQ_MEM_SKIP_EN
                else if (!mem_op_s) begin
                    next_s = ST_WRITE;
                end
`endif
                else begin
                    next_s = ST_MEM;
                end
            end
            ST_MEM: begin
                if (stall_s || (mem_op_s && !mem_ready)) begin
                    wait_inc_s = 1'b1;
                    if (at_limit_s) begin
                        next_s = ST_ERROR;
                    end else begin
                        next_s = ST_MEM;
                    end
                end else begin
                    next_s = ST_WRITE;
                end
            end
            ST_WRITE: next_s = ST_FETCH;
            ST_HALT:  next_s = ST_HALT;
            ST_ERROR: next_s = ST_ERROR;
            default:  next_s = ST_ERROR;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_WRITE) begin
            retire_r <= retire_r + CNT_W'(1);
        end else begin
            retire_r <= retire_r;
        end
    end

    assign fetch_en   = (state_r == ST_FETCH);
    assign decode_en  = (state_r == ST_DECODE);
    assign exec_en    = (state_r == ST_EXEC);
    assign mem_en     = (state_r == ST_MEM) && !stall_s;
    assign write_en   = (state_r == ST_WRITE);
    assign stage      = state_r;
    assign halted     = (state_r == ST_HALT);
    assign err        = (state_r == ST_ERROR);
    assign retire_cnt = retire_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench: directed vector table, hand-written timeout sequences, random episodes.
module tb_stage_sequencer;
    import seq_pkg::*;

`ifdef STAGE_SEQ_MEM_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam logic [4:0] S0 = 5'b00000;
    localparam logic [4:0] SF = 5'b10000;
    localparam logic [4:0] SD = 5'b01000;
    localparam logic [4:0] SE = 5'b00100;
    localparam logic [4:0] SM = 5'b00010;
    localparam logic [4:0] SW = 5'b00001;

    typedef struct {
        logic        rst, run, ld, st, hl, us, ub, mr;
        stage_e      stg;
        logic [4:0]  strb;
        logic        hlt, er;
        int unsigned ret;
    } vec_t;

    logic clk = 1'b0;
    logic rst, run, is_load, is_store, is_halt, uart_store, uart_busy, mem_ready;
    logic fetch_en, decode_en, exec_en, mem_en, write_en, halted, err;
    logic [2:0]  stage;
    logic [31:0] retire_cnt;
    logic fetch_en2, decode_en2, exec_en2, mem_en2, write_en2, halted2, err2;
    logic [2:0]  stage2;
    logic [3:0]  retire_cnt2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    stage_sequencer u_dut (
        .clk(clk), .rst(rst), .run(run), .is_load(is_load), .is_store(is_store),
        .is_halt(is_halt), .uart_store(uart_store), .uart_busy(uart_busy),
        .mem_ready(mem_ready), .fetch_en(fetch_en), .decode_en(decode_en),
        .exec_en(exec_en), .mem_en(mem_en), .write_en(write_en), .stage(stage),
        .halted(halted), .err(err), .retire_cnt(retire_cnt)
    );

    stage_sequencer #(.MEM_TIMEOUT(8), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .run(run), .is_load(is_load), .is_store(is_store),
        .is_halt(is_halt), .uart_store(uart_store), .uart_busy(uart_busy),
        .mem_ready(mem_ready), .fetch_en(fetch_en2), .decode_en(decode_en2),
        .exec_en(exec_en2), .mem_en(mem_en2), .write_en(write_en2), .stage(stage2),
        .halted(halted2), .err(err2), .retire_cnt(retire_cnt2)
    );

    wire logic [25:0] obs1 = {stage, fetch_en, decode_en, exec_en, mem_en, write_en,
                              halted, err, retire_cnt[15:0]};
    wire logic [25:0] obs2 = {stage2, fetch_en2, decode_en2, exec_en2, mem_en2, write_en2,
                              halted2, err2, 12'd0, retire_cnt2};

    function automatic vec_t mk(input logic [7:0] in, input stage_e s, input logic [4:0] sb,
                                input logic [1:0] hs, input int unsigned r);
        vec_t v;
        {v.rst, v.run, v.ld, v.st, v.hl, v.us, v.ub, v.mr} = in;
        v.stg  = s;
        v.strb = sb;
        {v.hlt, v.er} = hs;
        v.ret  = r;
        return v;
    endfunction

    function automatic logic [25:0] exp1(input vec_t v);
        logic [31:0] r;
        r = v.ret;
        return {v.stg, v.strb, v.hlt, v.er, r[15:0]};
    endfunction

    // The second instance has a 4-bit retire counter, so it sees the count modulo 16.
    function automatic logic [25:0] exp2(input vec_t v);
        logic [31:0] r;
        r = v.ret;
        return {v.stg, v.strb, v.hlt, v.er, 12'd0, r[3:0]};
    endfunction

    task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] want);
        total_cnt++;
        if (act === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h (stage/strobes/status/retire) want %h", nm, act, want);
        end
    endtask

    // mode 1: both instances share the expectation; mode 2: second instance only.
    task automatic apply(input vec_t v, input int mode, input string nm);
        @(posedge clk);
        #1;
        rst = v.rst; run = v.run; is_load = v.ld; is_store = v.st; is_halt = v.hl;
        uart_store = v.us; uart_busy = v.ub; mem_ready = v.mr;
        @(negedge clk);
        if (mode != 2) chk({nm, " dut"}, obs1, exp1(v));
        if (mode != 0) chk({nm, " dut2"}, obs2, exp2(v));
    endtask

    // Random episode: instruction mix built from the stage rules, optionally cut short by rst.
    task automatic random_episode(input int n_instr);
        vec_t q[$];
        int unsigned r = 0;
        int g, kind, b, d, t;
        logic [7:0] fl;
        g = $urandom_range(3, 0);
        for (int i = 0; i < g; i++) q.push_back(mk({2'b00, 6'($urandom)}, ST_IDLE, S0, 2'b00, 0));
        q.push_back(mk(8'b0100_0000, ST_IDLE, S0, 2'b00, 0));
        for (int i = 0; i <= n_instr; i++) begin
            kind = (i == n_instr) ? 4 : int'($urandom_range(3, 0));
            q.push_back(mk({1'b0, 7'($urandom)}, ST_FETCH, SF, 2'b00, r));
            q.push_back(mk({1'b0, 7'($urandom)}, ST_DECODE, SD, 2'b00, r));
            fl = {2'b00, kind == 1, kind == 2 || kind == 3, kind == 4, kind == 3, 2'b00};
            q.push_back(mk(fl, ST_EXEC, SE, 2'b00, r));
            if (kind == 4) begin
                q.push_back(mk({1'b0, 7'($urandom)}, ST_HALT, S0, 2'b10, r));
                q.push_back(mk({1'b0, 7'($urandom)}, ST_HALT, S0, 2'b10, r));
            end else begin
                if (kind == 0) begin
                    if (!SKIP) q.push_back(mk(fl | {6'b0, 2'($urandom)}, ST_MEM, SM, 2'b00, r));
                end else begin
                    b = (kind == 3) ? int'($urandom_range(3, 0)) : 0;
                    d = $urandom_range(4, 0);
                    for (int j = 0; j < b; j++)
                        q.push_back(mk(fl | 8'b0000_0010 | {7'b0, 1'($urandom)}, ST_MEM, S0, 2'b00, r));
                    for (int j = 0; j < d; j++) q.push_back(mk(fl, ST_MEM, SM, 2'b00, r));
                    q.push_back(mk(fl | 8'b0000_0001, ST_MEM, SM, 2'b00, r));
                end
                q.push_back(mk(fl, ST_WRITE, SW, 2'b00, r));
                r++;
            end
        end
        t = ($urandom_range(2, 0) == 0) ? int'($urandom_range(q.size() - 1, 0)) : q.size() - 1;
        while (q.size() > t + 1) void'(q.pop_back());
        q[t].rst = 1'b1;
        q.push_back(mk(8'b0000_0000, ST_IDLE, S0, 2'b00, 0));
        foreach (q[k]) apply(q[k], 1, "random");
    endtask

    initial begin
        vec_t tbl[$];
        rst = 1'b1; run = 1'b0; is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0;
        uart_store = 1'b0; uart_busy = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);

        // Reset beats run, then three ALU instructions.
        tbl.push_back(mk(8'b1100_0000, ST_IDLE, S0, 2'b00, 0));
        tbl.push_back(mk(8'b0000_0000, ST_IDLE, S0, 2'b00, 0));
        tbl.push_back(mk(8'b0100_0000, ST_IDLE, S0, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(8'b0100_1111, ST_FETCH, SF, 2'b00, i));
            tbl.push_back(mk(8'b0011_1001, ST_DECODE, SD, 2'b00, i));
            tbl.push_back(mk(8'b0000_0000, ST_EXEC, SE, 2'b00, i));
            if (!SKIP) tbl.push_back(mk(8'b0000_0000, ST_MEM, SM, 2'b00, i));
            tbl.push_back(mk(8'b0000_0000, ST_WRITE, SW, 2'b00, i));
        end
        // Load, ready on the fourth MEM cycle.
        tbl.push_back(mk(8'b0000_0000, ST_FETCH, SF, 2'b00, 3));
        tbl.push_back(mk(8'b0000_0000, ST_DECODE, SD, 2'b00, 3));
        tbl.push_back(mk(8'b0010_0000, ST_EXEC, SE, 2'b00, 3));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(8'b0010_0000, ST_MEM, SM, 2'b00, 3));
        tbl.push_back(mk(8'b0010_0001, ST_MEM, SM, 2'b00, 3));
        tbl.push_back(mk(8'b0010_0000, ST_WRITE, SW, 2'b00, 3));
        // UART store held off by a busy transmitter for six cycles.
        tbl.push_back(mk(8'b0000_0000, ST_FETCH, SF, 2'b00, 4));
        tbl.push_back(mk(8'b0000_0000, ST_DECODE, SD, 2'b00, 4));
        tbl.push_back(mk(8'b0001_0100, ST_EXEC, SE, 2'b00, 4));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(8'b0001_0111, ST_MEM, S0, 2'b00, 4));
        tbl.push_back(mk(8'b0001_0101, ST_MEM, SM, 2'b00, 4));
        tbl.push_back(mk(8'b0001_0100, ST_WRITE, SW, 2'b00, 4));
        // Halt is absorbing until reset.
        tbl.push_back(mk(8'b0000_0000, ST_FETCH, SF, 2'b00, 5));
        tbl.push_back(mk(8'b0000_0000, ST_DECODE, SD, 2'b00, 5));
        tbl.push_back(mk(8'b0000_1000, ST_EXEC, SE, 2'b00, 5));
        tbl.push_back(mk(8'b0110_0001, ST_HALT, S0, 2'b10, 5));
        tbl.push_back(mk(8'b0000_0000, ST_HALT, S0, 2'b10, 5));
        tbl.push_back(mk(8'b1000_0000, ST_HALT, S0, 2'b10, 5));
        tbl.push_back(mk(8'b0000_0000, ST_IDLE, S0, 2'b00, 0));
        foreach (tbl[i]) apply(tbl[i], 1, $sformatf("table[%0d]", i));

        // Load that never completes: the 8-cycle instance errors, the default one keeps waiting.
        apply(mk(8'b0100_0000, ST_IDLE, S0, 2'b00, 0), 1, "to run");
        apply(mk(8'b0000_0000, ST_FETCH, SF, 2'b00, 0), 1, "to fetch");
        apply(mk(8'b0000_0000, ST_DECODE, SD, 2'b00, 0), 1, "to decode");
        apply(mk(8'b0010_0000, ST_EXEC, SE, 2'b00, 0), 1, "to exec");
        for (int i = 0; i < 8; i++) apply(mk(8'b0010_0000, ST_MEM, SM, 2'b00, 0), 1, $sformatf("to mem%0d", i));
        apply(mk(8'b0110_1001, ST_ERROR, S0, 2'b01, 0), 2, "to error");
        chk("to default no error", {23'd0, stage}, {23'd0, ST_MEM});
        apply(mk(8'b0110_1001, ST_ERROR, S0, 2'b01, 0), 2, "to error sticky");
        apply(mk(8'b1000_0000, ST_ERROR, S0, 2'b01, 0), 2, "to rst");
        apply(mk(8'b0000_0000, ST_IDLE, S0, 2'b00, 0), 1, "to cleared");

        // Seven waits then ready: last cycle before the limit still completes.
        apply(mk(8'b0100_0000, ST_IDLE, S0, 2'b00, 0), 1, "bd run");
        apply(mk(8'b0000_0000, ST_FETCH, SF, 2'b00, 0), 1, "bd fetch");
        apply(mk(8'b0000_0000, ST_DECODE, SD, 2'b00, 0), 1, "bd decode");
        apply(mk(8'b0010_0000, ST_EXEC, SE, 2'b00, 0), 1, "bd exec");
        for (int i = 0; i < 7; i++) apply(mk(8'b0010_0000, ST_MEM, SM, 2'b00, 0), 1, "bd wait");
        apply(mk(8'b0010_0001, ST_MEM, SM, 2'b00, 0), 1, "bd ready");
        apply(mk(8'b0010_0000, ST_WRITE, SW, 2'b00, 0), 1, "bd write");
        apply(mk(8'b0000_0000, ST_FETCH, SF, 2'b00, 1), 1, "bd fetch2");
        apply(mk(8'b0000_0000, ST_DECODE, SD, 2'b00, 1), 1, "bd decode2");
        apply(mk(8'b0001_0000, ST_EXEC, SE, 2'b00, 1), 1, "bd exec2");
        apply(mk(8'b0001_0000, ST_MEM, SM, 2'b00, 1), 1, "bd mem2");
        apply(mk(8'b1001_0000, ST_MEM, SM, 2'b00, 1), 1, "bd rst mid-mem");
        apply(mk(8'b0000_0000, ST_IDLE, S0, 2'b00, 0), 1, "bd cleared");

        for (int e = 0; e < 12; e++) random_episode((e == 0) ? 20 : int'($urandom_range(6, 1)));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
